// File: rtl/williams2_nvram_upload_if.sv
// Signal bundle between hps_io upload requests, the CMOS read port and the
// autosave logic, as seen by the williams2 CMOS upload responder.
interface williams2_nvram_upload_if #(
   parameter int ADDR_W = 10
);
   logic              ioctl_upload;
   logic              ioctl_rd;
   logic [24:0]       ioctl_addr;
   logic [7:0]        ioctl_din;
   logic              ioctl_wait;
   logic [ADDR_W-1:0] cmos_addr;
   logic              cmos_rd;
   logic [3:0]        cmos_q;
   logic              cmos_we_mon;
   logic              dirty;
   logic              upload_done;

   // Requester side: hps_io, the CMOS RAM read port and the CPU write strobe.
   modport master (
      output ioctl_upload, ioctl_rd, ioctl_addr, cmos_q, cmos_we_mon,
      input  ioctl_din, ioctl_wait, cmos_addr, cmos_rd, dirty, upload_done
   );

   // Responder side: the upload block itself.
   modport slave (
      input  ioctl_upload, ioctl_rd, ioctl_addr, cmos_q, cmos_we_mon,
      output ioctl_din, ioctl_wait, cmos_addr, cmos_rd, dirty, upload_done
   );
endinterface

// File: rtl/williams2_nvram_upload.sv
// Serves HPS upload reads from the 4-bit williams2 CMOS RAM, packing two
// nibbles per byte, and tracks CPU writes so the top level can autosave.
module williams2_nvram_upload #(
   parameter int ADDR_W  = 10,
   parameter int RAM_LAT = 1
) (
   input logic                     clk_sys,
   input logic                     reset,
   williams2_nvram_upload_if.slave bus
);

   localparam int BYTE_W = ADDR_W - 1;
   localparam int CNT_W  = $clog2(RAM_LAT + 2);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAM_LAT);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LO   = 2'd1,
      HI   = 2'd2,
      OOR  = 2'd3
   } state_t;

   state_t            state;
   state_t            state_d;
   logic [CNT_W-1:0]  cnt;
   logic [BYTE_W-1:0] byte_addr;
   logic [3:0]        lo_nib;
   logic              upload_q;
   logic              last_ok;

   logic              in_range;
   logic              accept;
   logic              abort;
   logic              phase_end;
   logic              sess_rise;
   logic              sess_fall;

   assign in_range  = (bus.ioctl_addr >> BYTE_W) == 25'd0;
   assign sess_rise = bus.ioctl_upload & ~upload_q;
   assign sess_fall = ~bus.ioctl_upload & upload_q;

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_d;
      end
   end

   // A nibble phase lasts RAM_LAT+1 cycles; cnt reaching RAM_LAT marks the
   // cycle in which cmos_q holds the data for the address issued at its start.
   always_comb begin
      state_d   = state;
      accept    = 1'b0;
      abort     = 1'b0;
      phase_end = 1'b0;
      case (state)
         IDLE: begin
            if (bus.ioctl_rd && bus.ioctl_upload) begin
               accept  = 1'b1;
               state_d = in_range ? LO : OOR;
            end
         end
         LO, HI: begin
            if (!bus.ioctl_upload) begin
               abort   = 1'b1;
               state_d = IDLE;
            end else if (cnt == CNT_LAST) begin
               phase_end = 1'b1;
               state_d   = (state == LO) ? HI : IDLE;
            end
         end
         OOR: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         cnt            <= '0;
         byte_addr      <= '0;
         lo_nib         <= 4'h0;
         bus.cmos_addr  <= '0;
         bus.cmos_rd    <= 1'b0;
         bus.ioctl_din  <= 8'h00;
         bus.ioctl_wait <= 1'b0;
      end else begin
         bus.cmos_rd <= 1'b0;
         if (accept) begin
            byte_addr      <= bus.ioctl_addr[BYTE_W-1:0];
            cnt            <= '0;
            bus.ioctl_wait <= 1'b1;
            if (in_range) begin
               bus.cmos_addr <= {bus.ioctl_addr[BYTE_W-1:0], 1'b0};
               bus.cmos_rd   <= 1'b1;
            end
         end else if (abort) begin
            // ioctl_din deliberately keeps the last completed byte.
            bus.ioctl_wait <= 1'b0;
         end else if (phase_end) begin
            cnt <= '0;
            if (state == LO) begin
               lo_nib        <= bus.cmos_q;
               bus.cmos_addr <= {byte_addr, 1'b1};
               bus.cmos_rd   <= 1'b1;
            end else begin
               bus.ioctl_din  <= {bus.cmos_q, lo_nib};
               bus.ioctl_wait <= 1'b0;
            end
         end else if (state == OOR) begin
            bus.ioctl_din  <= 8'hFF;
            bus.ioctl_wait <= 1'b0;
         end else if ((state == LO) || (state == HI)) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   // Session bookkeeping: a session counts as complete only if the final byte
   // was actually returned before ioctl_upload fell.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         upload_q        <= 1'b0;
         last_ok         <= 1'b0;
         bus.upload_done <= 1'b0;
         bus.dirty       <= 1'b0;
      end else begin
         upload_q        <= bus.ioctl_upload;
         bus.upload_done <= sess_fall & last_ok;

         if (sess_rise) begin
            last_ok <= 1'b0;
         end else if (phase_end && (state == HI) && (byte_addr == '1)) begin
            last_ok <= 1'b1;
         end

         // A CPU write in the completion cycle must not be lost.
         if (bus.cmos_we_mon) begin
            bus.dirty <= 1'b1;
         end else if (sess_fall && last_ok) begin
            bus.dirty <= 1'b0;
         end
      end
   end

endmodule
